// File: rtl/tiny_dnn_ctrl.sv
// Job sequencer for the tiny_dnn_top accelerator: weight load, input exec stream,
// pipeline drain, and per-filter result readback onto a valid/ready stream.
module tiny_dnn_ctrl #(
    parameter int F_NUM  = 16,
    parameter int F_SIZE = 512,
    parameter int LW     = 10,
    localparam int FW    = $clog2(F_NUM),
    localparam int IW    = $clog2(F_SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic          wload_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    input  logic          w_valid_i,
    output logic          w_ready_o,
    input  logic [15:0]   w_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [15:0]   in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [31:0]   out_data_o,
    output logic [FW-1:0] out_idx_o,
    output logic          dnn_write_o,
    output logic          dnn_read_o,
    output logic          dnn_init_o,
    output logic          dnn_exec_o,
    output logic [FW+IW-1:0] dnn_a_o,
    output logic [31:0]   dnn_d_o,
    input  logic [31:0]   dnn_x_i
);

    typedef enum logic [3:0] {
        IDLE, WLOAD, INIT, EXEC, DRAIN, OUT_ADDR, OUT_CAP, OUT_HOLD, DONE
    } state_e;

    localparam logic [LW-1:0] LEN_MAX = LW'(F_SIZE);
    localparam logic [FW-1:0] F_LAST  = FW'(F_NUM - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [FW-1:0]     f_q, f_d;
    logic [LW-1:0]     len_q, len_d;
    logic              err_q, err_d;
    logic              write_q, write_d;
    logic              init_q, init_d;
    logic              exec_q, exec_d;
    logic [FW+IW-1:0]  a_q, a_d;
    logic [31:0]       d_q, d_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [FW-1:0]     out_idx_q, out_idx_d;
    logic              i_last;

    assign i_last = (LW'(i_q) == len_q - LW'(1));

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        f_d        = f_q;
        len_d      = len_q;
        err_d      = 1'b0;
        write_d    = 1'b0;
        init_d     = 1'b0;
        exec_d     = 1'b0;
        a_d        = a_q;
        d_d        = '0;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0 && len_i <= LEN_MAX) begin
                        len_d   = len_i;
                        i_d     = '0;
                        f_d     = '0;
                        state_d = wload_i ? WLOAD : INIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WLOAD: begin
                if (w_valid_i) begin
                    write_d = 1'b1;
                    a_d     = {f_q, i_q};
                    d_d     = {w_data_i, 16'h0000};
                    if (i_last) begin
                        i_d = '0;
                        if (f_q == F_LAST) begin
                            f_d     = '0;
                            state_d = INIT;
                        end else begin
                            f_d = f_q + FW'(1);
                        end
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
            end
            INIT: begin
                init_d  = 1'b1;
                i_d     = '0;
                state_d = EXEC;
            end
            EXEC: begin
                if (in_valid_i) begin
                    exec_d = 1'b1;
                    a_d    = {FW'(0), i_q};
                    d_d    = {in_data_i, 16'h0000};
                    if (i_last) begin
                        i_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
            end
            DRAIN: begin
                // i_q doubles as the two-cycle drain counter
                if (i_q[0]) begin
                    i_d     = '0;
                    f_d     = '0;
                    a_d     = '0;
                    state_d = OUT_ADDR;
                end else begin
                    i_d = IW'(1);
                end
            end
            OUT_ADDR: state_d = OUT_CAP;
            OUT_CAP: begin
                out_data_d = dnn_x_i;
                out_idx_d  = f_q;
                state_d    = OUT_HOLD;
            end
            OUT_HOLD: begin
                if (out_ready_i) begin
                    if (f_q == F_LAST) begin
                        f_d     = '0;
                        state_d = DONE;
                    end else begin
                        f_d     = f_q + FW'(1);
                        a_d     = {f_q + FW'(1), IW'(0)};
                        state_d = OUT_ADDR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            i_q        <= '0;
            f_q        <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            write_q    <= 1'b0;
            init_q     <= 1'b0;
            exec_q     <= 1'b0;
            a_q        <= '0;
            d_q        <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            f_q        <= f_d;
            len_q      <= len_d;
            err_q      <= err_d;
            write_q    <= write_d;
            init_q     <= init_d;
            exec_q     <= exec_d;
            a_q        <= a_d;
            d_q        <= d_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign w_ready_o   = (state_q == WLOAD);
    assign in_ready_o  = (state_q == EXEC);
    assign out_valid_o = (state_q == OUT_HOLD);
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign dnn_write_o = write_q;
    assign dnn_read_o  = 1'b0;
    assign dnn_init_o  = init_q;
    assign dnn_exec_o  = exec_q;
    assign dnn_a_o     = a_q;
    assign dnn_d_o     = d_q;

endmodule

// File: tb/tb_tiny_dnn_ctrl.sv
// Directed bench for tiny_dnn_ctrl with a small behavioural accelerator model
// (weight store, real-valued accumulators, one-cycle normalizer register).
module tb_tiny_dnn_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, wload, w_valid, in_valid, out_ready;
    logic [9:0]  len;
    logic [15:0] w_data, in_data;
    logic        busy, done, err, w_ready, in_ready, out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        dnn_write, dnn_read, dnn_init, dnn_exec;
    logic [12:0] dnn_a;
    logic [31:0] dnn_d;
    logic [31:0] norm_q;

    tiny_dnn_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .wload_i(wload),
        .busy_o(busy), .done_o(done), .err_o(err),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_idx_o(out_idx),
        .dnn_write_o(dnn_write), .dnn_read_o(dnn_read), .dnn_init_o(dnn_init),
        .dnn_exec_o(dnn_exec), .dnn_a_o(dnn_a), .dnn_d_o(dnn_d), .dnn_x_i(norm_q)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- accelerator model ----------------
    function automatic real bf2real(input logic [15:0] b);
        logic [63:0] db;
        if (b[14:0] == 15'h0) return 0.0;
        db = {b[15], 11'(int'(b[14:7]) - 127 + 1023), b[6:0], 45'h0};
        return $bitstoreal(db);
    endfunction

    function automatic logic [31:0] real2f(input real r);
        logic [63:0] db;
        if (r == 0.0) return 32'h0;
        db = $realtobits(r);
        return {db[63], 8'(int'(db[62:52]) - 1023 + 127), db[51:29]};
    endfunction

    logic [15:0] wmem [16][512];
    real         acc [16];

    always @(posedge clk) begin
        if (dnn_write) wmem[dnn_a[12:9]][dnn_a[8:0]] <= dnn_d[31:16];
        if (dnn_init) begin
            for (int f = 0; f < 16; f++) acc[f] <= 0.0;
        end
        if (dnn_exec) begin
            for (int f = 0; f < 16; f++)
                acc[f] <= acc[f] + bf2real(wmem[f][dnn_a[8:0]]) * bf2real(dnn_d[31:16]);
        end
        norm_q <= real2f(acc[dnn_a[12:9]]);
    end

    // ---------------- command monitor ----------------
    logic [12:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [12:0] ex_a[$];
    always @(negedge clk) begin
        if (dnn_write) begin
            wr_a.push_back(dnn_a);
            wr_d.push_back(dnn_d);
        end
        if (dnn_exec) ex_a.push_back(dnn_a);
    end

    // ---------------- job driver ----------------
    logic [31:0] res_data [16];
    logic [3:0]  res_idx  [16];
    logic [31:0] st_data  [10];
    logic [3:0]  st_idx   [10];
    logic [12:0] st_a     [10];
    logic [3:0]  st_cmd   [10];
    int          res_n, done_cnt, stall_n, cycles;
    logic        busy_after;

    task automatic drive_job(input int n, input bit wl, input bit wsplit,
                             input logic [15:0] xval, input bit gaps,
                             input int stall_idx, input bit poke);
        int wbeats, stall_cnt, start_cyc, budget;
        bit fin;
        res_n = 0; done_cnt = 0; stall_n = 0; cycles = 0;
        wbeats = 0; stall_cnt = 0; budget = 0; fin = 0;
        start = 1'b1; len = n[9:0]; wload = wl; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        while (!fin && budget < 5000) begin
            w_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            w_data   = (wsplit && (wbeats / n) >= 8) ? 16'h4000 : 16'h3F80;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = xval;
            start    = poke && in_ready;
            len      = 10'd4;
            out_ready = 1'b1;
            if (out_valid && int'(out_idx) == stall_idx && stall_cnt < 10) begin
                out_ready = 1'b0;
                st_data[stall_cnt] = out_data;
                st_idx[stall_cnt]  = out_idx;
                st_a[stall_cnt]    = dnn_a;
                st_cmd[stall_cnt]  = {dnn_write, dnn_read, dnn_init, dnn_exec};
                stall_cnt++;
                stall_n = stall_cnt;
            end
            if (w_valid && w_ready) wbeats++;
            if (out_valid && out_ready) begin
                $display("result idx=%0d data=%08h", out_idx, out_data);
                if (res_n < 16) begin
                    res_data[res_n] = out_data;
                    res_idx[res_n]  = out_idx;
                end
                res_n++;
            end
            if (done) begin
                done_cnt++;
                cycles = cyc - start_cyc + 1;
                fin = 1;
            end
            @(negedge clk);
            budget++;
        end
        w_valid = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        if (!fin) begin
            vectors++; miscompares++;
            $display("FAIL job_timeout: done not seen after %0d cycles, required within 5000", budget);
        end
        repeat (6) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        busy_after = busy;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] got;
        rst_n = 1'b0; start = 0; len = 0; wload = 0; w_valid = 0; in_valid = 0;
        w_data = 0; in_data = 0; out_ready = 1;
        repeat (3) @(negedge clk);
        got = {26'h0, busy, done, err, w_ready, in_ready, out_valid};
        vectors++;
        if (got !== 32'h0) begin
            miscompares++; $display("FAIL reset_status: got %h required 0", got);
        end
        vectors++;
        if ({out_data, out_idx, dnn_write, dnn_read, dnn_init, dnn_exec, dnn_a, dnn_d} !== '0) begin
            miscompares++;
            $display("FAIL reset_datapath: got data=%h idx=%h a=%h d=%h required all 0",
                     out_data, out_idx, dnn_a, dnn_d);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset applied");
    endtask

    task automatic test_single();
        int base;
        logic [31:0] exp;
        base = wr_a.size();
        drive_job(1, 1'b1, 1'b1, 16'h3F80, 1'b0, -1, 1'b0);
        vectors++;
        if (wr_a.size() - base != 16) begin
            miscompares++; $display("FAIL single_write_count: got %0d required 16", wr_a.size() - base);
        end else begin
            for (int k = 0; k < 16; k++) begin
                vectors++;
                if (wr_a[base + k] !== 13'(k << 9) ||
                    wr_d[base + k] !== ((k < 8) ? 32'h3F800000 : 32'h40000000)) begin
                    miscompares++;
                    $display("FAIL single_write_beat%0d: got a=%h d=%h required a=%h", k,
                             wr_a[base + k], wr_d[base + k], 13'(k << 9));
                end
            end
        end
        vectors++;
        if (res_n != 16) begin
            miscompares++; $display("FAIL single_result_count: got %0d required 16", res_n);
        end
        for (int k = 0; k < 16; k++) begin
            exp = (k < 8) ? 32'h3F800000 : 32'h40000000;
            vectors++;
            if (res_data[k] !== exp || res_idx[k] !== 4'(k)) begin
                miscompares++;
                $display("FAIL single_result%0d: got idx=%0d data=%h required idx=%0d data=%h",
                         k, res_idx[k], res_data[k], k, exp);
            end
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++; $display("FAIL single_done: got %0d pulses required 1", done_cnt);
        end
    endtask

    task automatic test_accumulate();
        int base;
        base = ex_a.size();
        drive_job(4, 1'b1, 1'b0, 16'h3F80, 1'b0, -1, 1'b0);
        vectors++;
        if (ex_a.size() - base != 4) begin
            miscompares++; $display("FAIL acc_exec_count: got %0d required 4", ex_a.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (ex_a[base + k] !== 13'(k)) begin
                    miscompares++;
                    $display("FAIL acc_exec_addr%0d: got %h required %h", k, ex_a[base + k], 13'(k));
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (res_data[k] !== 32'h40800000 || res_idx[k] !== 4'(k)) begin
                miscompares++;
                $display("FAIL acc_result%0d: got idx=%0d data=%h required 40800000", k, res_idx[k], res_data[k]);
            end
        end
        vectors++;
        if (cycles != 121) begin
            miscompares++; $display("FAIL acc_cycles: got %0d required 121", cycles);
        end
    endtask

    task automatic test_reuse();
        int base;
        base = wr_a.size();
        drive_job(4, 1'b0, 1'b0, 16'h4000, 1'b0, -1, 1'b0);
        vectors++;
        if (wr_a.size() != base) begin
            miscompares++; $display("FAIL reuse_no_write: got %0d writes required 0", wr_a.size() - base);
        end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (res_data[k] !== 32'h41000000 || res_idx[k] !== 4'(k)) begin
                miscompares++;
                $display("FAIL reuse_result%0d: got idx=%0d data=%h required 41000000", k, res_idx[k], res_data[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        drive_job(4, 1'b1, 1'b0, 16'h3F80, 1'b1, 3, 1'b0);
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (res_data[k] !== 32'h40800000 || res_idx[k] !== 4'(k)) begin
                miscompares++;
                $display("FAIL bp_result%0d: got idx=%0d data=%h required 40800000", k, res_idx[k], res_data[k]);
            end
        end
        vectors++;
        if (stall_n != 10) begin
            miscompares++; $display("FAIL bp_stall_count: got %0d required 10", stall_n);
        end
        for (int k = 0; k < stall_n; k++) begin
            vectors++;
            if (st_data[k] !== 32'h40800000 || st_idx[k] !== 4'd3 ||
                st_a[k] !== {4'd3, 9'd0} || st_cmd[k] !== 4'h0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got data=%h idx=%0d a=%h cmd=%b required 40800000/3/0600/0000",
                         k, st_data[k], st_idx[k], st_a[k], st_cmd[k]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [9:0] bad [2];
        bad[0] = 10'd0;
        bad[1] = 10'd513;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; len = bad[k]; wload = 1'b1;
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_len%0d_err: got err=%b busy=%b required err=1 busy=0", bad[k], err, busy);
            end
            @(negedge clk);
            vectors++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_len%0d_pulse: got err=%b busy=%b required 0 0", bad[k], err, busy);
            end
            $display("illegal start len=%0d rejected", bad[k]);
        end
    endtask

    task automatic test_start_during_exec();
        drive_job(4, 1'b0, 1'b0, 16'h3F80, 1'b0, -1, 1'b1);
        vectors++;
        if (done_cnt != 1 || busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL exec_start_ignored: got done=%0d busy=%b required done=1 busy=0", done_cnt, busy_after);
        end
        vectors++;
        if (res_data[15] !== 32'h40800000 || res_n != 16) begin
            miscompares++;
            $display("FAIL exec_start_result: got n=%0d last=%h required 16 40800000", res_n, res_data[15]);
        end
    endtask

    task automatic test_reset_midjob();
        int beats, budget;
        start = 1'b1; len = 10'd4; wload = 1'b0;
        @(negedge clk);
        start = 1'b0;
        beats = 0; budget = 0;
        while (beats < 2 && budget < 100) begin
            in_valid = 1'b1; in_data = 16'h3F80;
            if (in_ready) beats++;
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, err, w_ready, in_ready, out_valid, out_data, out_idx,
             dnn_write, dnn_read, dnn_init, dnn_exec, dnn_a, dnn_d} !== '0 || beats != 2) begin
            miscompares++;
            $display("FAIL midjob_reset: got busy=%b in_ready=%b a=%h d=%h beats=%0d required all 0 after 2 beats",
                     busy, in_ready, dnn_a, dnn_d, beats);
        end
        rst_n = 1'b1;
        @(negedge clk);
        drive_job(4, 1'b1, 1'b0, 16'h3F80, 1'b0, -1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (res_data[k] !== 32'h40800000 || res_idx[k] !== 4'(k)) begin
                miscompares++;
                $display("FAIL midjob_result%0d: got idx=%0d data=%h required 40800000", k, res_idx[k], res_data[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_accumulate();
        test_reuse();
        test_backpressure();
        test_illegal();
        test_start_during_exec();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
